// File: rtl/pc_pkg.sv
// ============================================================================
// Module  : pc_pkg
// Purpose : Shared defaults and op-select encoding for program_counter_stack.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam int DEF_ADDR_W      = 9;
    localparam int DEF_STACK_DEPTH = 8;

    // Output of the strobe priority encoder; only one op acts per cycle.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_INC  = 3'd1,
        OP_REL  = 3'd2,
        OP_LOAD = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_t;

endpackage

`default_nettype wire

// File: rtl/pc_return_stack.sv
// ============================================================================
// Module  : pc_return_stack
// Purpose : Return-address LIFO; drops pushes when full, ignores pops when empty.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_return_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         full,
    output logic                         empty,
    output logic                         err
);

    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [IDX_W:0]    sp;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              do_push;
    logic              do_pop;

    assign full    = (sp == (IDX_W+1)'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;
    assign err     = (push && full) || (pop && empty);

    // When sp==STACK_DEPTH the low bits wrap to 0, so rd_idx lands on the last slot.
    assign wr_idx = sp[IDX_W-1:0];
    assign rd_idx = wr_idx - IDX_W'(1);
    assign top    = mem[rd_idx];
    assign depth  = sp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + (IDX_W+1)'(1);
        end else if (do_pop) begin
            sp <= sp - (IDX_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_counter_stack.sv
// ============================================================================
// Module  : program_counter_stack
// Purpose : PC with load/inc/relative branch and call/return stack.
//           Optional trap-on-stack-fault enabled by macro PC_STACK_TRAP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module program_counter_stack
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                STACK_DEPTH = DEF_STACK_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
`ifdef PC_STACK_TRAP_EN
   ,parameter logic [ADDR_W-1:0] TRAP_ADDR   = '1
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pc_load,
    input  logic                         pc_inc,
    input  logic                         pc_rel,
    input  logic                         pc_call,
    input  logic                         pc_ret,
    input  logic                         pc_enOut,
    input  logic [ADDR_W-1:0]            in_value,
    input  logic [ADDR_W-1:0]            rel_offset,
    output logic [ADDR_W-1:0]            out_value,
    output logic [ADDR_W-1:0]            pc_value,
    output logic [$clog2(STACK_DEPTH):0] stk_depth,
    output logic                         stk_err
);

    op_t               op;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] stk_top;
    logic              push;
    logic              pop;
    logic              stk_full;
    logic              stk_empty;
    logic              stk_fault;

    always_comb begin
        op = OP_NONE;
        if (pc_ret)       op = OP_RET;
        else if (pc_call) op = OP_CALL;
        else if (pc_load) op = OP_LOAD;
        else if (pc_rel)  op = OP_REL;
        else if (pc_inc)  op = OP_INC;
    end

    assign push     = (op == OP_CALL);
    assign pop      = (op == OP_RET);
    assign pc_plus1 = pc + ADDR_W'(1);

    pc_return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .top       (stk_top),
        .depth     (stk_depth),
        .full      (stk_full),
        .empty     (stk_empty),
        .err       (stk_fault)
    );

    always_comb begin
        pc_next = pc;
        case (op)
            OP_INC:  pc_next = pc_plus1;
            OP_REL:  pc_next = pc + rel_offset;
            OP_LOAD: pc_next = in_value;
            OP_CALL: pc_next = in_value;
            OP_RET:  pc_next = stk_empty ? pc : stk_top;
            default: pc_next = pc;
        endcase
`ifdef PC_STACK_TRAP_EN
        if (stk_fault) pc_next = TRAP_ADDR;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_ADDR;
            stk_err <= 1'b0;
        end else begin
            pc <= pc_next;
            if (stk_fault) stk_err <= 1'b1;
        end
    end

    assign pc_value  = pc;
    assign out_value = pc_enOut ? pc : '0;

    // The stack's fault pulse must agree with its own full/empty view.
    assert property (@(posedge clk) disable iff (rst)
        stk_fault == ((push && stk_full) || (pop && stk_empty)));

endmodule

`default_nettype wire

// File: tb/tb_program_counter_stack.sv
// Directed bench: each step queues its expected PC/stack state, the post-edge sample pops it.
`default_nettype none

module tb_program_counter_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pc_load = 0, pc_inc = 0, pc_rel = 0, pc_call = 0, pc_ret = 0;
    logic       pc_enOut = 1'b1;
    logic [8:0] in_value = '0, rel_offset = '0;
    logic [8:0] out_value, pc_value;
    logic [3:0] stk_depth;
    logic       stk_err;

`ifdef PC_STACK_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [8:0] pc;
        logic [3:0] depth;
        logic       err;
        logic [8:0] outv;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    program_counter_stack dut (
        .clk(clk), .rst(rst),
        .pc_load(pc_load), .pc_inc(pc_inc), .pc_rel(pc_rel),
        .pc_call(pc_call), .pc_ret(pc_ret), .pc_enOut(pc_enOut),
        .in_value(in_value), .rel_offset(rel_offset),
        .out_value(out_value), .pc_value(pc_value),
        .stk_depth(stk_depth), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic ld, inc, rel, call, ret, en,
                         input logic [8:0] inv, off);
        pc_load = ld; pc_inc = inc; pc_rel = rel; pc_call = call; pc_ret = ret;
        pc_enOut = en; in_value = inv; rel_offset = off;
    endtask

    task automatic expect_state(input string tag, input logic [8:0] pc,
                                input logic [3:0] depth, input logic err);
        exp_t e;
        e.tag = tag; e.pc = pc; e.depth = depth; e.err = err;
        e.outv = pc_enOut ? pc : 9'h000;
        q.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (q.size() == 0) begin
            checks++; errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = q.pop_front();
        checks++;
        assert (pc_value === e.pc) else begin
            errors++; $error("FAIL %s.pc observed=%h expected=%h", e.tag, pc_value, e.pc);
        end
        checks++;
        assert (out_value === e.outv) else begin
            errors++; $error("FAIL %s.out observed=%h expected=%h", e.tag, out_value, e.outv);
        end
        checks++;
        assert (stk_depth === e.depth) else begin
            errors++; $error("FAIL %s.depth observed=%0d expected=%0d", e.tag, stk_depth, e.depth);
        end
        checks++;
        assert (stk_err === e.err) else begin
            errors++; $error("FAIL %s.err observed=%b expected=%b", e.tag, stk_err, e.err);
        end
    endtask

    // Clock one edge with the current strobes, then check the queued expectation.
    task automatic step(input string tag, input logic [8:0] pc,
                        input logic [3:0] depth, input logic err);
        expect_state(tag, pc, depth, err);
        @(posedge clk); #1;
        compare_front();
        drive(0, 0, 0, 0, 0, pc_enOut, in_value, rel_offset);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        expect_state("reset", 9'h000, 4'd0, 1'b0); compare_front();

        // Load, increment, output gating
        drive(1, 0, 0, 0, 0, 1, 9'b111001100, 9'h0); step("load", 9'b111001100, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 9'h0, 9'h0);         step("inc",  9'b111001101, 0, 0);
        pc_enOut = 1'b0; #1;
        expect_state("gate_off", 9'b111001101, 0, 0); compare_front();
        pc_enOut = 1'b1;
        step("hold", 9'b111001101, 0, 0);

        // Wrap and relative branches
        drive(1, 0, 0, 0, 0, 1, 9'h1FF, 9'h0);  step("load_1ff", 9'h1FF, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 9'h0, 9'h0);    step("inc_wrap", 9'h000, 0, 0);
        drive(0, 0, 1, 0, 0, 1, 9'h0, 9'h1FE);  step("rel_m2",   9'h1FE, 0, 0);
        drive(0, 0, 1, 0, 0, 1, 9'h0, 9'h004);  step("rel_p4",   9'h002, 0, 0);

        // Nested call / return
        drive(1, 0, 0, 0, 0, 1, 9'h010, 9'h0);  step("load_010", 9'h010, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 9'h100, 9'h0);  step("call1",    9'h100, 1, 0);
        drive(0, 0, 0, 1, 0, 1, 9'h180, 9'h0);  step("call2",    9'h180, 2, 0);
        drive(0, 0, 0, 0, 1, 1, 9'h0, 9'h0);    step("ret1",     9'h101, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 9'h0, 9'h0);    step("ret2",     9'h011, 0, 0);

        // Priority
        drive(1, 0, 0, 0, 0, 1, 9'h020, 9'h0);  step("load_020", 9'h020, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 9'h050, 9'h0);  step("call_050", 9'h050, 1, 0);
        drive(0, 1, 0, 1, 1, 1, 9'h0EE, 9'h0);  step("pri_ret",  9'h021, 0, 0);
        drive(1, 1, 0, 0, 0, 1, 9'h0AA, 9'h0);  step("pri_load", 9'h0AA, 0, 0);
        drive(0, 1, 1, 0, 0, 1, 9'h0, 9'h003);  step("pri_rel",  9'h0AD, 0, 0);
        drive(1, 0, 0, 1, 0, 1, 9'h0C0, 9'h0);  step("pri_call", 9'h0C0, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 9'h0, 9'h0);    step("ret_0ae",  9'h0AE, 0, 0);

        // Underflow from reset
        do_reset();
        drive(0, 0, 0, 0, 1, 1, 9'h0, 9'h0);
        step("underflow", TRAP ? 9'h1FF : 9'h000, 0, 1);

        // Overflow: eight good calls then one dropped push
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 9'h030, 9'h0);  step("load_030", 9'h030, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1, 0, 1, 9'h040 + 9'(i), 9'h0);
            step("fill", 9'h040 + 9'(i), 4'(i + 1), 0);
        end
        drive(0, 0, 0, 1, 0, 1, 9'h070, 9'h0);
        step("overflow", TRAP ? 9'h1FF : 9'h070, 8, 1);
        drive(0, 0, 0, 0, 1, 1, 9'h0, 9'h0);    step("ret_top",  9'h047, 7, 1);

        // Async reset between edges while a call is pending
        drive(0, 0, 0, 1, 0, 1, 9'h123, 9'h0);
        #3 rst = 1'b1;
        #1;
        expect_state("async_rst", 9'h000, 0, 0); compare_front();
        drive(0, 0, 0, 0, 0, 1, 9'h0, 9'h0);
        @(posedge clk); #1;
        expect_state("rst_held", 9'h000, 0, 0); compare_front();
        rst = 1'b0;
        drive(0, 1, 0, 0, 0, 1, 9'h0, 9'h0);    step("post_rst", 9'h001, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
